// File: rtl/riscv_mdu.sv
// riscv_mdu: iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide retire one bit per cycle on
// unsigned magnitudes; sign correction happens in the FIX state.
// Divide-by-zero and signed overflow skip straight to FIX.
// Optional build macro MDU_FAST_MUL_EN: MUL-class ops use a single-cycle
// combinational multiplier instead of the iterative loop.
module riscv_mdu #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t state_q, state_d;

  logic [2:0]          f3_q;
  logic [2*DATA_W-1:0] acc_q;     // mul: {hi, multiplier/lo}; div: {rem, quo}
  logic [DATA_W-1:0]   opd_q;     // multiplicand or divisor magnitude
  logic                neg_q;     // negate product / quotient
  logic                neg_rem_q; // negate remainder
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   result_q;
  logic                done_q;

  // issue-side decode
  logic              is_div, a_signed, b_signed, a_neg, b_neg;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic              div_zero, div_ovf, fast_mul, fast;

  // iteration and fix-up datapath
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_nxt;
  logic [DATA_W:0]     div_shl, div_diff;
  logic                div_ge;
  logic [2*DATA_W-1:0] div_nxt;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix, fix_res;

  // Decode signedness and magnitudes of the incoming operands
  always_comb begin
    is_div   = funct3[2];
    a_signed = funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
    b_signed = funct3 inside {3'b001, 3'b100, 3'b110};
    a_neg    = a_signed & op_a[DATA_W-1];
    b_neg    = b_signed & op_b[DATA_W-1];
    mag_a    = a_neg ? -op_a : op_a;
    mag_b    = b_neg ? -op_b : op_b;
    div_zero = is_div && (op_b == '0);
    div_ovf  = is_div && !funct3[0] &&
               (op_a == {1'b1, {(DATA_W-1){1'b0}}}) && (op_b == '1);
`ifdef MDU_FAST_MUL_EN
    fast_mul = !is_div;
`else
    fast_mul = 1'b0;
`endif
    fast     = div_zero || div_ovf || fast_mul;
  end

  // One shift-add step and one restoring-divide step
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} +
               (acc_q[0] ? {1'b0, opd_q} : {(DATA_W+1){1'b0}});
    mul_nxt  = {mul_sum, acc_q[DATA_W-1:1]};
    div_shl  = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    div_diff = div_shl - {1'b0, opd_q};
    div_ge   = div_shl >= {1'b0, opd_q};
    div_nxt  = {(div_ge ? div_diff[DATA_W-1:0] : div_shl[DATA_W-1:0]),
                acc_q[DATA_W-2:0], div_ge};
  end

  // Sign correction and result select applied in FIX
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
    fix_res  = '0;
    if (f3_q[2])
      fix_res = f3_q[1] ? rem_fix : quo_fix;
    else if (f3_q[1:0] == 2'b00)
      fix_res = prod_fix[DATA_W-1:0];
    else
      fix_res = prod_fix[2*DATA_W-1:DATA_W];
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush wins over everything, including start
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = fast ? S_FIX : (is_div ? S_DIV : S_MUL);
        S_MUL,
        S_DIV:   if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        S_FIX:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs: busy follows state, done and result are registered
  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = done_q;
    result = result_q;
  end

  // Datapath: operand capture, iteration, and result load in FIX
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f3_q      <= '0;
      acc_q     <= '0;
      opd_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!flush) begin
        case (state_q)
          S_IDLE: if (start) begin
            f3_q      <= funct3;
            cnt_q     <= CNT_W'(DATA_W);
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (div_zero) begin
              // quotient all ones, remainder is the raw dividend
              acc_q     <= {op_a, {DATA_W{1'b1}}};
              neg_q     <= 1'b0;
              neg_rem_q <= 1'b0;
            end else if (div_ovf) begin
              // quotient is the raw dividend, remainder zero
              acc_q     <= {{DATA_W{1'b0}}, op_a};
              neg_q     <= 1'b0;
              neg_rem_q <= 1'b0;
            end else if (is_div) begin
              acc_q <= {{DATA_W{1'b0}}, mag_a};
              opd_q <= mag_b;
            end else begin
`ifdef MDU_FAST_MUL_EN
              acc_q <= {{DATA_W{1'b0}}, mag_a} * {{DATA_W{1'b0}}, mag_b};
`else
              acc_q <= {{DATA_W{1'b0}}, mag_b};
`endif
              opd_q <= mag_a;
            end
          end
          S_MUL: begin
            acc_q <= mul_nxt;
            cnt_q <= cnt_q - CNT_W'(1);
          end
          S_DIV: begin
            acc_q <= div_nxt;
            cnt_q <= cnt_q - CNT_W'(1);
          end
          S_FIX: begin
            result_q <= fix_res;
            done_q   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/riscv_mdu.md
Name: riscv_mdu

Overview:
Parametrised iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the riscv core.
- Sits beside the ALU in the EX stage.
- Datapath issues an operation with a start pulse and stalls the pipeline while busy is high.
- Shift-add multiply and restoring divide: one bit per cycle, sign correction applied on the final cycle.

Parameters:
DATA_W, 32, operand and result width (any even value >= 8)
CNT_W, $clog2(DATA_W)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous abort of the in-flight operation
start  input  1  request; sampled only when busy=0
funct3  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  DATA_W  rs1 value (multiplicand / dividend)
op_b  input  DATA_W  rs2 value (multiplier / divisor)
busy  output  1  operation in progress; datapath must hold EX
done  output  1  one-cycle pulse, result valid
result  output  DATA_W  registered result, held until next accepted start

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, busy=0, done=0, result=0, counter=0, internal accumulators 0. Reset mid-operation discards the operation; no done pulse.
- States:
  - IDLE: start=1 at edge n latches funct3, operand magnitudes and sign flags, then goes to MUL or DIV (or FIX via the fast path); busy=1 from edge n.
  - MUL: each edge adds the multiplicand to the 2*DATA_W product if the multiplier LSB is 1, then shifts. DATA_W iterations, counter decrements to 0, then FIX.
  - DIV: restoring division, one quotient bit per edge. DATA_W iterations, then FIX.
  - FIX: applies sign correction, loads result, pulses done=1, clears busy, returns to IDLE.
- Latency: start sampled at edge n gives done=1 and busy=0 in the cycle between edges n+DATA_W+1 and n+DATA_W+2.
- Signedness:
  - MULH and DIV/REM treat both operands as signed; MULHSU treats op_a signed and op_b unsigned; MULHU, DIVU and REMU treat both as unsigned.
  - Operands are converted to magnitude. The product is negated if the signs differ. The quotient is negated if the signs differ. The remainder takes the dividend's sign.
- Result select: MUL returns product[DATA_W-1:0]; MULH, MULHSU and MULHU return product[2*DATA_W-1:DATA_W]; DIV/DIVU return the quotient; REM/REMU return the remainder.
- Fast path (start edge goes directly to FIX, done in the cycle after edge n+1):
  - Divide by zero: quotient = all ones, remainder = op_a.
  - Signed overflow (DIV/REM with op_a = most-negative, op_b = -1): quotient = op_a, remainder = 0.
- start while busy=1: ignored, no queuing.
- start in the same cycle done=1: accepted, so back-to-back issue is legal.
- flush=1: at the next edge state becomes IDLE, busy=0, no done pulse, result unchanged. flush has priority over start in the same cycle.
- result changes only in FIX and at reset.

Optional Feature:
MDU_FAST_MUL_EN
- Defined: MUL-class operations use a single combinational DATA_W x DATA_W multiplier. start at edge n goes directly to FIX, so done arrives in the cycle after edge n+1. Divide timing is unchanged.
- Undefined: iterative multiply as described above; no multiplier primitive is inferred.

Test Plan:
- Basic MUL: DATA_W=32, MUL op_a=7, op_b=0xFFFFFFFD -> result 0xFFFFFFEB; done exactly 33 cycles after the start edge (iterative build); busy high throughout.
- High-half multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- Special cases:
  - DIV x / 0 with x=0x1234 -> 0xFFFFFFFF; REM x / 0 -> 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0.
  - All of these give done in the cycle after edge n+1.
- Flush and reset: flush at cycle 10 of a DIV -> busy=0 next edge, no done, result keeps its old value. Reset low at cycle 5 of a MUL -> busy=0, result=0 immediately. start during busy is ignored.
- Back-to-back: second start asserted in the done cycle of MUL 3x4=12 with DIVU 12/5 -> results 12 then 2, second done 33 cycles after the first done. With MDU_FAST_MUL_EN defined, MUL 3x4 -> done after 2 cycles.
